// File: rtl/lc3_decode.sv
// lc3_decode: decode stage of the LC3 pipeline.
// Captures the fetched instruction and its PC+1 when decode is enabled and
// turns the opcode into the control bundle consumed by execute, memory and
// writeback. Everything leaves the block from a flop, and every field
// loads on the same edge. This means IR and the control word always
// describe the same instruction.
module lc3_decode (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [5:0]  E_Control,
  output logic [1:0]  W_Control,
  output logic        Mem_Control
);

  // LC3 opcodes (instruction bits [15:12])
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  // ALU operation codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  // Address offset select for the execute-stage adder
  localparam logic [1:0] PCS1_NONE = 2'b00;
  localparam logic [1:0] PCS1_OFF9 = 2'b01;
  localparam logic [1:0] PCS1_OFF6 = 2'b10;
  localparam logic [1:0] PCS1_ZERO = 2'b11;

  // Writeback source select. Code 2'b11 is never generated.
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_PC  = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  logic [3:0]  opcode;

  logic [1:0]  alu_control_d;
  logic [1:0]  pcselect1_d;
  logic        pcselect2_d;
  logic        op2select_d;
  logic [1:0]  w_control_d;
  logic        mem_control_d;

  logic [15:0] ir_q;
  logic [15:0] npc_q;
  logic [5:0]  e_control_q;
  logic [1:0]  w_control_q;
  logic        mem_control_q;

  assign opcode = dout[15:12];

  // Decode the incoming opcode into the next control fields. Opcodes the
  // core does not support (JSR, RTI, reserved, TRAP) fall through to the
  // all-zero defaults. They are passed along as harmless no-ops, and no
  // error is flagged.
  always_comb begin
    alu_control_d = ALU_ADD;
    pcselect1_d   = PCS1_NONE;
    pcselect2_d   = 1'b0;
    op2select_d   = 1'b0;
    w_control_d   = WB_ALU;
    mem_control_d = 1'b0;

    case (opcode)
      OP_ADD: begin
        alu_control_d = ALU_ADD;
        // IR[5] set selects imm5, so the register operand is its inverse
        op2select_d   = ~dout[5];
        w_control_d   = WB_ALU;
      end
      OP_AND: begin
        alu_control_d = ALU_AND;
        op2select_d   = ~dout[5];
        w_control_d   = WB_ALU;
      end
      OP_NOT: begin
        alu_control_d = ALU_NOT;
        op2select_d   = 1'b1;
        w_control_d   = WB_ALU;
      end
      OP_BR: begin
        pcselect1_d = PCS1_OFF9;
        pcselect2_d = 1'b1;
      end
      OP_LD: begin
        pcselect1_d = PCS1_OFF9;
        pcselect2_d = 1'b1;
        w_control_d = WB_MEM;
      end
      OP_LDI: begin
        pcselect1_d   = PCS1_OFF9;
        pcselect2_d   = 1'b1;
        w_control_d   = WB_MEM;
        mem_control_d = 1'b1;
      end
      OP_LEA: begin
        pcselect1_d = PCS1_OFF9;
        pcselect2_d = 1'b1;
        w_control_d = WB_PC;
      end
      OP_ST: begin
        pcselect1_d = PCS1_OFF9;
        pcselect2_d = 1'b1;
      end
      OP_STI: begin
        pcselect1_d   = PCS1_OFF9;
        pcselect2_d   = 1'b1;
        mem_control_d = 1'b1;
      end
      OP_LDR: begin
        // Base comes from a register, so pcselect2 stays 0
        pcselect1_d = PCS1_OFF6;
        w_control_d = WB_MEM;
      end
      OP_STR: begin
        pcselect1_d = PCS1_OFF6;
      end
      OP_JMP: begin
        pcselect1_d = PCS1_ZERO;
      end
      default: begin
        // unsupported opcode: keep the all-zero defaults
      end
    endcase
  end

  // Pipeline register. Reset clears every field and wins over the enable.
  // Without enable, every field holds its value together.
  always_ff @(posedge clock) begin
    if (reset) begin
      ir_q          <= 16'h0000;
      npc_q         <= 16'h0000;
      e_control_q   <= 6'b000000;
      w_control_q   <= 2'b00;
      mem_control_q <= 1'b0;
    end else if (enable_decode) begin
      ir_q          <= dout;
      npc_q         <= npc_in;
      e_control_q   <= {alu_control_d, pcselect1_d, pcselect2_d, op2select_d};
      w_control_q   <= w_control_d;
      mem_control_q <= mem_control_d;
    end
  end

  assign IR          = ir_q;
  assign npc_out     = npc_q;
  assign E_Control   = e_control_q;
  assign W_Control   = w_control_q;
  assign Mem_Control = mem_control_q;

endmodule

// File: tb/tb_lc3_decode.sv
// Testbench for lc3_decode. The opcode table and the corner-case sequences
// carry hand-derived expected bundles. Each step queues its expected bundle
// when it drives the inputs. The bundle is popped and compared just after
// the edge that captures those inputs.
module tb_lc3_decode;

  logic        clock;
  logic        reset;
  logic        enable_decode;
  logic [15:0] dout;
  logic [15:0] npc_in;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [5:0]  e;
    logic [1:0]  w;
    logic        m;
  } out_t;

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] n;
    logic [5:0]  e;
    logic [1:0]  w;
    logic        m;
  } vec_t;

  vec_t vecs[$];
  out_t sb_q[$];
  out_t zero_out;
  out_t last_out;
  int   tests_run;
  int   tests_failed;

  lc3_decode dut (
    .clock        (clock),
    .reset        (reset),
    .enable_decode(enable_decode),
    .dout         (dout),
    .npc_in       (npc_in),
    .IR           (IR),
    .npc_out      (npc_out),
    .E_Control    (E_Control),
    .W_Control    (W_Control),
    .Mem_Control  (Mem_Control)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle and queue its expected result. Wait for the edge, then
  // pop the expected result and compare it 1 time unit after the edge.
  task automatic step(input logic rst, input logic en, input logic [15:0] d,
                      input logic [15:0] n, input out_t exp, input string name);
    out_t got;
    out_t want;
    reset         = rst;
    enable_decode = en;
    dout          = d;
    npc_in        = n;
    sb_q.push_back(exp);
    @(posedge clock);
    #1;
    got  = '{IR, npc_out, E_Control, W_Control, Mem_Control};
    want = sb_q.pop_front();
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got IR=%h npc=%h E=%b W=%b M=%b, want IR=%h npc=%h E=%b W=%b M=%b",
               name, got.ir, got.npc, got.e, got.w, got.m,
               want.ir, want.npc, want.e, want.w, want.m);
    end else begin
      $display("[TB] %s: IR=%h npc=%h E=%b W=%b M=%b ok",
               name, got.ir, got.npc, got.e, got.w, got.m);
    end
    last_out = got;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    zero_out     = '0;
    last_out     = '0;
    reset        = 1'b1;
    enable_decode = 1'b0;
    dout         = 16'h0000;
    npc_in       = 16'h0000;

    // dout, npc_in, expected E_Control, W_Control, Mem_Control
    vecs.push_back('{16'h1283, 16'h3001, 6'b000001, 2'b00, 1'b0}); // ADD reg
    vecs.push_back('{16'h5262, 16'h3002, 6'b010000, 2'b00, 1'b0}); // AND imm
    vecs.push_back('{16'hA005, 16'h3003, 6'b000110, 2'b10, 1'b1}); // LDI
    vecs.push_back('{16'h6283, 16'h3004, 6'b001000, 2'b10, 1'b0}); // LDR
    vecs.push_back('{16'hC0C0, 16'h3005, 6'b001100, 2'b00, 1'b0}); // JMP
    vecs.push_back('{16'hE1FF, 16'h3006, 6'b000110, 2'b01, 1'b0}); // LEA
    vecs.push_back('{16'hF025, 16'h3007, 6'b000000, 2'b00, 1'b0}); // TRAP
    vecs.push_back('{16'h0E02, 16'h3008, 6'b000110, 2'b00, 1'b0}); // BR
    vecs.push_back('{16'h2005, 16'h3009, 6'b000110, 2'b10, 1'b0}); // LD
    vecs.push_back('{16'h3005, 16'h300A, 6'b000110, 2'b00, 1'b0}); // ST
    vecs.push_back('{16'hB005, 16'h300B, 6'b000110, 2'b00, 1'b1}); // STI
    vecs.push_back('{16'h7283, 16'h300C, 6'b001000, 2'b00, 1'b0}); // STR
    vecs.push_back('{16'h907F, 16'h300D, 6'b100001, 2'b00, 1'b0}); // NOT
    vecs.push_back('{16'h1261, 16'h300E, 6'b000000, 2'b00, 1'b0}); // ADD imm
    vecs.push_back('{16'h5283, 16'h300F, 6'b010001, 2'b00, 1'b0}); // AND reg
    vecs.push_back('{16'h4800, 16'h3010, 6'b000000, 2'b00, 1'b0}); // JSR
    vecs.push_back('{16'h8000, 16'h3011, 6'b000000, 2'b00, 1'b0}); // RTI
    vecs.push_back('{16'hD000, 16'h3012, 6'b000000, 2'b00, 1'b0}); // reserved

    // Reset while enable and an ADD are presented: outputs stay zero
    step(1'b1, 1'b1, 16'h1283, 16'h3001, zero_out, "reset_0");
    step(1'b1, 1'b1, 16'h1283, 16'h3001, zero_out, "reset_1");
    // The first edge after reset captures the ADD
    step(1'b0, 1'b1, 16'h1283, 16'h3001,
         '{16'h1283, 16'h3001, 6'b000001, 2'b00, 1'b0}, "post_reset_add");

    // Table: back-to-back enabled cycles, one instruction per cycle
    foreach (vecs[i]) begin
      step(1'b0, 1'b1, vecs[i].d, vecs[i].n,
           '{vecs[i].d, vecs[i].n, vecs[i].e, vecs[i].w, vecs[i].m},
           $sformatf("vec%0d_%h", i, vecs[i].d));
    end

    // Enable gating: capture LEA, then hold through 5 disabled cycles
    step(1'b0, 1'b1, 16'hE1FF, 16'h4000,
         '{16'hE1FF, 16'h4000, 6'b000110, 2'b01, 1'b0}, "gate_lea");
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 16'h1283, 16'h5555,
           '{16'hE1FF, 16'h4000, 6'b000110, 2'b01, 1'b0},
           $sformatf("gate_hold%0d", k));
    end

    // Reset mid-stream between two enabled ADDs
    step(1'b0, 1'b1, 16'h1283, 16'h6001,
         '{16'h1283, 16'h6001, 6'b000001, 2'b00, 1'b0}, "mid_add_a");
    step(1'b1, 1'b1, 16'h5262, 16'h6002, zero_out, "mid_reset");
    step(1'b0, 1'b1, 16'h1261, 16'h6003,
         '{16'h1261, 16'h6003, 6'b000000, 2'b00, 1'b0}, "mid_add_b");

    // Disabled after reset: the zero state must also hold
    step(1'b1, 1'b0, 16'hA005, 16'h7000, zero_out, "reset_no_en");
    step(1'b0, 1'b0, 16'hA005, 16'h7001, zero_out, "hold_zero");

    if (sb_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lc3_decode.md
# lc3_decode

Pipelined decode stage of the LC3 core. It registers the fetched instruction and next-PC, and drives the execute, memory and writeback control fields. These outputs form the decode_out interface bundle consumed by the execute stage. The block has a single clock domain and one register stage; fields update only while decode is enabled.

## Interface

- No parameters; all widths are fixed by the LC3 ISA.
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- enable_decode  input  1  qualifies capture of dout/npc_in on the rising edge
- dout  input  16  instruction word from fetch/IMEM
- npc_in  input  16  PC+1 from fetch
- IR  output  16  registered instruction
- npc_out  output  16  registered npc_in
- E_Control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
- W_Control  output  2  writeback source select
- Mem_Control  output  1  indirect-access flag for memory stage

## Operation

- Opcode is dout[15:12], decoded combinationally; all outputs are flops.
- alu_control field:
  - ADD (0001) = 00; AND (0101) = 01; NOT (1001) = 10.
  - All other opcodes = 00.
- pcselect1 field:
  - 01 (IR[8:0] offset) for BR 0000, LD 0010, LDI 1010, LEA 1110, ST 0011, STI 1011.
  - 10 (IR[5:0] offset) for LDR 0110, STR 0111.
  - 11 (zero offset) for JMP 1100.
  - 00 otherwise.
- pcselect2 field:
  - 1 (base = npc) for BR, LD, LDI, LEA, ST, STI.
  - 0 (base = register) for JMP, LDR, STR, ALU ops and illegal opcodes.
- op2select field:
  - ADD/AND: ~dout[5] (1 = register source, 0 = imm5).
  - NOT: 1.
  - All others: 0.
- W_Control:
  - 00 = ALU result for ADD, AND, NOT.
  - 01 = computed PC for LEA.
  - 10 = memory data for LD, LDR, LDI.
  - 00 for all other opcodes.
  - Code 11 is never produced.
- Mem_Control: 1 for LDI and STI; 0 otherwise.
- Unsupported opcodes (0100, 1000, 1101, 1111):
  - IR and npc_out are still captured.
  - All control fields = 0.
  - No error is flagged.

## Timing

- Reset (reset=1 at a rising edge): IR, npc_out, E_Control, W_Control, Mem_Control all = 0 after that edge. Reset has priority over enable_decode.
- Latency is 1 cycle. When enable_decode=1 at edge N, every output reflects dout/npc_in sampled at edge N, visible after edge N.
- When enable_decode=0, every output holds its previous value indefinitely.
- All fields update together. No output may mix the old and new instruction in the same cycle.
- Back-to-back enables: a new instruction is accepted every cycle with no bubble.
- Reset asserted mid-stream: the pending instruction is discarded. The first enable after reset deassertion captures normally.
- Inputs are sampled only at the rising edge. Changes between edges have no effect.

## Test plan

- Reset with enable_decode=1 and dout=0x1283: all outputs 0 for the duration of reset; the first edge after reset captures 0x1283.
- ADD R1,R2,R3 (dout=0x1283, npc_in=0x3001): one cycle later IR=0x1283, npc_out=0x3001, E_Control=000001, W_Control=00, Mem_Control=0.
- AND immediate, then LDI, then LDR, then JMP, on four consecutive enabled cycles:
  - AND imm (0x5262): E_Control=010000, W_Control=00, Mem_Control=0.
  - LDI (0xA005): E_Control=000110, W_Control=10, Mem_Control=1.
  - LDR (0x6283): E_Control=001000, W_Control=10, Mem_Control=0.
  - JMP (0xC0C0): E_Control=001100, W_Control=00, Mem_Control=0.
  - Each result appears exactly one cycle after its input.
- Enable gating: capture LEA 0xE1FF with W_Control=01, then drop enable_decode for 5 cycles while driving 0x1283. Outputs hold the LEA values for all 5 cycles.
- Illegal opcode 0xF025 (TRAP): IR=0xF025 and npc_out is captured; E_Control=0, W_Control=0, Mem_Control=0.
- Reset mid-stream: assert reset for one cycle between two enabled ADDs. Outputs go to 0 after that edge, and the next enabled ADD is decoded correctly.
